// File: rtl/pwm_capture.sv
// pwm_capture: measures high/low phase widths of an asynchronous PWM input and flags a stuck line.
// Optional deglitch filter on the synchronized level: define PWM_CAPTURE_DEGLITCH_EN.
module pwm_capture #(
   parameter int unsigned CNT_W      = 28,
   parameter int unsigned SHIFT      = 24,
   parameter int unsigned TIMEOUT    = (1 << 28) - 1,
   parameter int unsigned GLITCH_CYC = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_width,
   output logic [CNT_W-1:0] low_width,
   output logic [3:0]       duty_code,
   output logic             valid,
   output logic             stuck
);

   typedef enum logic [1:0] {ACQUIRE, HIGH, LOW} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
`ifdef PWM_CAPTURE_DEGLITCH_EN
   localparam logic [2:0] PRIME = 3'd4;
`else
   localparam logic [2:0] PRIME = 3'd3;
`endif

   if (TIMEOUT == 0 || 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
      $error("pwm_capture: TIMEOUT must be in 1 .. 2**CNT_W-1");
   end
   if (GLITCH_CYC == 0) begin : g_bad_glitch
      $error("pwm_capture: GLITCH_CYC must be at least 1");
   end

   logic       s1, s, prev, lvl;
   logic [2:0] fill;
   logic       primed, rise, fall;

   // Reset values in the synchronizer are not pin samples; edges are masked until
   // prev holds a real sample, so a line already high at release is not a rise.
   assign primed = (fill == PRIME);
   assign rise   = primed &  lvl & ~prev;
   assign fall   = primed & ~lvl &  prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1   <= 1'b0;
         s    <= 1'b0;
         prev <= 1'b0;
         fill <= '0;
      end else begin
         s1   <= pwm_in;
         s    <= s1;
         prev <= lvl;
         if (!primed) fill <= fill + 3'd1;
      end
   end

`ifdef PWM_CAPTURE_DEGLITCH_EN
   localparam int unsigned GW = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;
   logic [GW-1:0] gcnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl  <= 1'b0;
         gcnt <= '0;
      end else if (!primed) begin
         lvl  <= s;
         gcnt <= '0;
      end else if (s == lvl) begin
         gcnt <= '0;
      end else if (gcnt == GW'(GLITCH_CYC - 1)) begin
         lvl  <= s;
         gcnt <= '0;
      end else begin
         gcnt <= gcnt + GW'(1);
      end
   end
`else
   assign lvl = s;
`endif

   function automatic logic [3:0] duty_of(input logic [CNT_W-1:0] w);
      logic [CNT_W-1:0] q;
      q = (w - CNT_W'(1)) >> SHIFT;
      return (|(q >> 4)) ? 4'hF : q[3:0];
   endfunction

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ACQUIRE;
         cnt        <= '0;
         pending    <= '0;
         high_width <= '0;
         low_width  <= '0;
         duty_code  <= '0;
         valid      <= 1'b0;
         stuck      <= 1'b0;
      end else begin
         valid <= 1'b0;

         if (rise || fall)        cnt <= '0;
         else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);

         // An edge in the same cycle as the timeout wins.
         if (!(rise || fall) && cnt == CNT_MAX) begin
            stuck <= 1'b1;
            state <= ACQUIRE;
         end else begin
            case (state)
               ACQUIRE: if (rise) state <= HIGH;
               HIGH: begin
                  if (fall) begin
                     pending <= cnt + CNT_W'(1);
                     state   <= LOW;
                  end
               end
               LOW: begin
                  if (rise) begin
                     high_width <= pending;
                     low_width  <= cnt + CNT_W'(1);
                     duty_code  <= duty_of(pending);
                     valid      <= 1'b1;
                     stuck      <= 1'b0;
                     state      <= HIGH;
                  end
               end
               default: state <= ACQUIRE;
            endcase
         end
      end
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator.
- Samples an asynchronous PWM/square-wave input and measures high-phase and low-phase widths in clk cycles.
- Reports each completed period with a one-cycle valid strobe and derives a 4-bit duty code from the high-phase width.
- Flags a stuck input when no edge arrives within a timeout; used for loopback self-test and external PWM decoding.

Parameters:
- CNT_W, 28, width of the width counters and width outputs.
- SHIFT, 24, right-shift applied to (high_width-1) to form duty_code.
- TIMEOUT, 2^28-1, cycles without an edge before stuck asserts; must be ≤ 2^CNT_W-1.
- GLITCH_CYC, 3, stability cycles required by the deglitch filter (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- high_width  out  CNT_W  cycles the input was high in the last complete period.
- low_width  out  CNT_W  cycles the input was low in the last complete period.
- duty_code  out  4  min(15, (high_width-1) >> SHIFT).
- valid  out  1  one-cycle strobe: new high_width/low_width/duty_code available.
- stuck  out  1  level: timeout expired with no edge.

Behaviour:
- Reset is asynchronous, active-high. All registers clear immediately, including mid-measurement: outputs 0, state ACQUIRE, counter 0, synchronizer 0.
- Synchronizer:
  - 2-flop synchronizer on pwm_in gives s; one more register gives prev.
  - rise = s & ~prev; fall = ~s & prev.
  - "lvl" below is s, or the deglitched level when the optional feature is compiled in.
- Counter:
  - cnt clears to 0 on any edge cycle; otherwise it increments.
  - cnt holds at TIMEOUT-1 once reached; it never wraps.
  - Measured width = cnt + 1, captured on the terminating edge cycle.
- FSM states: ACQUIRE, HIGH, LOW.
  - ACQUIRE: falls are ignored, so the first partial phase is discarded. A rise moves to HIGH.
  - HIGH: a fall captures high_width_pending = cnt+1 and moves to LOW.
  - LOW: a rise registers high_width ← pending, low_width ← cnt+1, duty_code, and valid=1 on the next cycle, then moves to HIGH. stuck clears with valid.
- Latency: valid asserts 3 clk cycles after the pwm_in rise that completes the period (2 sync stages + 1 output register), without the deglitch feature.
- Outputs hold their last values between valid strobes.
- duty_code:
  - Computed as (width-1) >> SHIFT; any bits above 4 force 15.
  - width is ≥1 by construction, so there is no underflow.
- Timeout:
  - cnt reaching TIMEOUT-1 in any state with no edge that cycle sets stuck=1 on the next cycle and forces ACQUIRE.
  - stuck stays set until the next valid or reset.
  - Timeout does not modify the width outputs.
- Simultaneous timeout and edge: the edge wins. The edge is processed normally and no stuck is raised.
- Minimum resolvable phase is 1 synchronized cycle. Pulses shorter than one clk period may be missed, and this is acceptable.

Optional Feature:
- Macro: PWM_CAPTURE_DEGLITCH_EN.
- Defined:
  - lvl changes only after s differs from lvl for GLITCH_CYC consecutive cycles.
  - Shorter excursions are ignored and do not reset cnt.
  - Both edges are delayed equally, so measured widths are unchanged.
  - valid latency becomes 3+GLITCH_CYC cycles.
- Undefined: lvl = s; no filter logic is synthesized.

Test Plan:
- Bench parameters: CNT_W=8, SHIFT=2, TIMEOUT=200.
- Reset: assert reset asynchronously between clock edges -> all outputs 0 immediately. After release with pwm_in=0 for 50 cycles -> valid never pulses, stuck=0.
- Steady square wave, high 9 / low 9, starting low -> first valid after first full high+low. Then high_width=9, low_width=9, duty_code=2. valid repeats every 18 cycles, 3 cycles after each pin rise.
- Start mid-high (pwm_in=1 at reset release, fall at cycle 5), then high 12 / low 7 -> first fall ignored. First valid reports 12/7, duty_code=2.
- Saturation: high 100 / low 20 -> duty_code=15 (99>>2=24), high_width=100, low_width=20.
- Stuck and recovery: hold pwm_in high 250 cycles after a valid period -> stuck=1 about 200 cycles after the rise, widths unchanged. Resume 10/10 square wave -> stuck clears on the first new valid with 10/10.
- Reset mid-measurement and deglitch:
  - Assert reset during the LOW phase -> valid does not fire for that period, and measurement restarts in ACQUIRE.
  - With PWM_CAPTURE_DEGLITCH_EN, a 2-cycle glitch inside a 20-cycle high phase -> widths still report 20.
